// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word-array memory slave with one-cycle completion pulse
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

  state_t                r_state;
  logic [3:0]            r_count;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic                  r_rd;
  logic                  r_wr;
  logic                  r_resp;
  logic                  r_busy;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_req;
  logic                  w_req_rd;
  logic [ADDR_WIDTH-1:0] w_req_idx;
  logic                  w_unused;

  assign w_req     = mem_read | mem_write;
  // A simultaneous read and write is serviced as a write only.
  assign w_req_rd  = mem_read & ~mem_write;
  assign w_req_idx = mem_address[ADDR_WIDTH+1:2];
  assign w_unused  = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'h0;
      r_be    <= 4'h0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_resp  <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_resp <= 1'b0;
          if (w_req) begin
            r_idx   <= w_req_idx;
            r_wdata <= mem_wdata;
            r_be    <= mem_byte_enable;
            r_rd    <= w_req_rd;
            r_wr    <= mem_write;
            r_count <= LOAD;
            r_busy  <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= ST_RESP;
              r_resp  <= 1'b1;
              if (w_req_rd) r_rdata <= r_mem[w_req_idx];
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count <= 4'd1) begin
            r_state <= ST_RESP;
            r_resp  <= 1'b1;
            if (r_rd) r_rdata <= r_mem[r_idx];
          end
        end
        ST_RESP: begin
          r_resp  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_resp  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Writes commit on the edge leaving RESP; reset forces IDLE first, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (r_state == ST_RESP && r_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign mem_resp  = r_resp;
  assign mem_rdata = r_rdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed and randomized checks of mem_responder at LATENCY 2 and 1
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        t_rd = 1'b0;
  logic        t_wr = 1'b0;
  logic [3:0]  t_be = 4'h0;
  logic [31:0] t_addr = 32'h0;
  logic [31:0] t_wdata = 32'h0;

  logic        resp0, busy0, resp1, busy1;
  logic [31:0] rdata0, rdata1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model [2][1024];
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .mem_read(t_rd & ~sel), .mem_write(t_wr & ~sel),
    .mem_byte_enable(t_be), .mem_address(t_addr), .mem_wdata(t_wdata),
    .mem_resp(resp0), .mem_rdata(rdata0), .busy(busy0)
  );

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .mem_read(t_rd & sel), .mem_write(t_wr & sel),
    .mem_byte_enable(t_be), .mem_address(t_addr), .mem_wdata(t_wdata),
    .mem_resp(resp1), .mem_rdata(rdata1), .busy(busy1)
  );

  wire        cur_resp  = sel ? resp1 : resp0;
  wire        cur_busy  = sel ? busy1 : busy0;
  wire [31:0] cur_rdata = sel ? rdata1 : rdata0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0 ] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic txn(input logic s, input logic rd, input logic wr, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit drop);
    bit seen;
    int k;
    int lat;
    k = s ? 1 : 0;
    lat = s ? 1 : 2;
    seen = 0;
    @(negedge clk);
    sel = s; t_rd = rd; t_wr = wr; t_be = be; t_addr = addr; t_wdata = wdata;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      chk("busy_in_txn", {31'h0, cur_busy}, 32'h1);
      if (cur_resp) begin
        seen = 1;
        chk("resp_latency", 32'(n), 32'(lat));
        chk("rdata_at_resp", cur_rdata, (rd && !wr) ? model[k][widx(addr)] : exp_rd[k]);
      end
      if (n == 1 && drop) begin
        t_rd = 1'b0; t_wr = 1'b0;
        t_be = 4'($urandom()); t_addr = $urandom(); t_wdata = $urandom();
      end
      if (seen) begin
        t_rd = 1'b0; t_wr = 1'b0;
      end
    end
    if (!seen) chk("resp_timeout", 32'h0, 32'h1);
    if (wr) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model[k][widx(addr)][8*i +: 8] = wdata[8*i +: 8];
    end else if (rd) begin
      exp_rd[k] = model[k][widx(addr)];
    end
    @(negedge clk);
    chk("idle_resp", {31'h0, cur_resp}, 32'h0);
    chk("idle_busy", {31'h0, cur_busy}, 32'h0);
  endtask

  initial begin
    int pulses, first, second, consec, cnt;
    logic prev;
    logic [31:0] r;

    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;

    #2;
    chk("rst_resp0", {31'h0, resp0}, 32'h0);
    chk("rst_busy0", {31'h0, busy0}, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_resp1", {31'h0, resp1}, 32'h0);
    chk("rst_busy1", {31'h0, busy1}, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(0, 0, 1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 0);
    txn(0, 1, 0, 4'hF, 32'h0000_0010, 32'h0, 0);
    chk("read_deadbeef", exp_rd[0], 32'hDEADBEEF);

    txn(0, 0, 1, 4'b0101, 32'h0000_0010, 32'h11223344, 0);
    txn(0, 1, 0, 4'hF, 32'h0000_0010, 32'h0, 0);
    chk("partial_write", rdata0, 32'hDE22BE44);
    txn(0, 0, 1, 4'b0000, 32'h0000_0010, 32'hFFFFFFFF, 0);
    txn(0, 1, 0, 4'hF, 32'h0000_0010, 32'h0, 0);
    chk("be_zero_write", rdata0, 32'hDE22BE44);

    txn(0, 0, 1, 4'hF, 32'h0000_1003, 32'hA5A5A5A5, 0);
    txn(0, 1, 0, 4'h0, 32'h0000_0000, 32'h0, 0);
    chk("alias_read", rdata0, 32'hA5A5A5A5);

    txn(0, 0, 1, 4'hF, 32'h0000_0020, 32'h13579BDF, 0);
    @(negedge clk);
    sel = 0; t_rd = 1'b1; t_wr = 1'b0; t_be = 4'hF; t_addr = 32'h0000_0020;
    pulses = 0; first = 0; second = 0; consec = 0; prev = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (resp0) begin
        pulses++;
        if (prev) consec++;
        if (pulses == 1) first = n; else second = n;
        chk("b2b_rdata", rdata0, 32'h13579BDF);
      end
      prev = resp0;
      if (n == 4) t_rd = 1'b0;
    end
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_first", 32'(first), 32'd2);
    chk("b2b_spacing", 32'(second - first), 32'd3);
    chk("b2b_consecutive", 32'(consec), 32'd0);
    exp_rd[0] = 32'h13579BDF;

    txn(0, 0, 1, 4'hF, 32'h0000_0040, 32'h12345678, 0);
    @(negedge clk);
    sel = 0; t_wr = 1'b1; t_rd = 1'b0; t_be = 4'hF; t_addr = 32'h0000_0040; t_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("abort_busy_wait", {31'h0, busy0}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy0}, 32'h0);
    chk("abort_resp", {31'h0, resp0}, 32'h0);
    chk("abort_rdata", rdata0, 32'h0);
    t_wr = 1'b0;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (resp0) cnt++;
    end
    chk("abort_no_resp", 32'(cnt), 32'd0);
    txn(0, 1, 0, 4'hF, 32'h0000_0040, 32'h0, 0);
    chk("abort_mem_kept", rdata0, 32'h12345678);

    txn(0, 1, 1, 4'hF, 32'h0000_0080, 32'hCAFEF00D, 0);
    chk("rw_rdata_kept", rdata0, 32'h12345678);
    txn(0, 1, 0, 4'hF, 32'h0000_0080, 32'h0, 0);
    chk("rw_is_write", rdata0, 32'hCAFEF00D);

    txn(1, 0, 1, 4'hF, 32'h0000_0008, 32'h55AA1234, 0);
    txn(1, 1, 0, 4'hF, 32'h0000_0008, 32'h0, 0);
    chk("l1_read", rdata1, 32'h55AA1234);
    txn(1, 1, 1, 4'hF, 32'h0000_0008, 32'hCAFEF00D, 0);
    chk("l1_rw_rdata_kept", rdata1, 32'h55AA1234);
    txn(1, 1, 0, 4'hF, 32'h0000_0008, 32'h0, 0);
    chk("l1_rw_is_write", rdata1, 32'hCAFEF00D);

    for (int w = 0; w < 16; w++) begin
      txn(0, 0, 1, 4'hF, 32'(w * 4), $urandom(), 0);
      txn(1, 0, 1, 4'hF, 32'(w * 4), $urandom(), 0);
    end
    for (int t = 0; t < 40; t++) begin
      logic        s;
      int          op;
      logic [3:0]  wsel;
      s = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      wsel = 4'($urandom_range(0, 15));
      r = $urandom();
      txn(s, op != 1, op != 0, 4'($urandom()), {r[31:12], 6'b0, wsel, r[1:0]},
          $urandom(), $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Synthesizable memory-side responder for the processor's memory port: accepts read/write requests from the CPU top level, services them from an internal word array after a fixed latency, and completes each transaction with a one-cycle `mem_resp` pulse. Used as the on-chip/bench memory behind the processor, and as the reference slave when verifying the control FSM's request-hold-until-response behaviour.

## Interface

Parameters:
- `ADDR_WIDTH`, 10: log2 of word depth; the array holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 2: cycles from request acceptance to `mem_resp`; legal range 1..15.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mem_read` input 1: read request, held by the initiator until `mem_resp`.
- `mem_write` input 1: write request, held by the initiator until `mem_resp`.
- `mem_byte_enable` input 4: write lane enables; bit i selects `mem_wdata[8i+7:8i]`.
- `mem_address` input 32: byte address.
- `mem_wdata` input 32: write data.
- `mem_resp` output 1: one-cycle completion pulse.
- `mem_rdata` output 32: read data; valid in the `mem_resp` cycle of a read.
- `busy` output 1: high while a transaction is accepted and not yet completed.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: if `mem_read | mem_write` is high at a rising edge, latch the address, `mem_wdata`, `mem_byte_enable`, and op type, and load the countdown with LATENCY-1. Next state is RESP if LATENCY==1, else WAIT.
- WAIT: decrement the count each edge; move to RESP when the count reaches 0.
- RESP: `mem_resp`=1 for exactly one cycle; next state is always IDLE.
- Word index = latched `address[ADDR_WIDTH+1:2]`. Bits [1:0] are ignored. Upper bits are ignored, so addresses alias modulo 4*2^ADDR_WIDTH.
- Read: `mem_rdata` is loaded from the array on the edge entering RESP, and holds its value until the next read's RESP. All 4 bytes are returned regardless of `mem_byte_enable`.
- Write: only enabled byte lanes are updated, on the edge leaving RESP. `mem_byte_enable`=0000 still completes with `mem_resp` but changes nothing. A write does not alter `mem_rdata`.
- `mem_read` and `mem_write` both high at acceptance: treated as a write, and `mem_rdata` is unchanged.
- Request inputs are sampled only at acceptance. Changes during WAIT or RESP are ignored. A request that drops before `mem_resp` is still completed.
- `busy` = (state != IDLE).
- Array contents are not affected by reset. Contents are undefined until written.

## Timing

- Reset values: state IDLE, `mem_resp`=0, `busy`=0, `mem_rdata`=32'h0, countdown 0.
- Asserting `rst_n` low mid-transaction aborts it immediately: no `mem_resp`, and a pending write is discarded (array untouched).
- Latency: a request accepted at edge k gives `mem_resp` high in the cycle after edge k+LATENCY-1, i.e. LATENCY cycles after the request cycle.
- The earliest next acceptance is the edge ending the RESP cycle +1. The IDLE cycle following RESP samples the request lines. An initiator still driving `mem_read` after RESP starts a new transaction; this is the intended back-to-back behaviour.
- Throughput: one transaction per LATENCY+1 cycles.
- Read-after-write to the same word: the write commits on the edge leaving RESP, so the next read returns the new data.

## Test plan

- Reset, then write 32'hDEADBEEF, be=1111, addr 32'h0000_0010 (LATENCY=2), then read the same address -> `mem_resp` 2 cycles after each request, `mem_rdata`=32'hDEADBEEF, `busy` high for exactly 2 cycles per transaction.
- Partial write: word 0x10 holds 32'hDEADBEEF; write 32'h11223344 with be=0101 -> read returns 32'hDE22BE44. Then write with be=0000 -> read still returns 32'hDE22BE44.
- Aliasing and byte offset (ADDR_WIDTH=10): write 32'hA5A5A5A5 to 32'h0000_1003 -> read of 32'h0000_0000 returns 32'hA5A5A5A5.
- Back-to-back: `mem_read` held through `mem_resp` and the following cycle -> a second transaction starts, with `mem_resp` pulses spaced exactly LATENCY+1 cycles apart and never two consecutive high cycles.
- Reset mid-write: start a write of 32'hFFFFFFFF to a word holding 32'h12345678, and pull `rst_n` low during WAIT -> `mem_resp` never pulses, `busy`=0 immediately, and a later read returns 32'h12345678.
- Simultaneous `mem_read` and `mem_write` with wdata 32'hCAFEF00D -> treated as a write: `mem_rdata` unchanged at `mem_resp`, and a later read returns 32'hCAFEF00D. Repeat with LATENCY=1 -> `mem_resp` in the cycle after the request.
